// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and fetch outputs between the sequencer and its datapath/bench.
interface pc_sequencer_if #(parameter int CNT_W = 16);
  logic             start;
  logic             stall;
  logic [2:0]       opcode;
  logic             branch_taken;
  logic [7:0]       branch_offset;
  logic             jump;
  logic [7:0]       jump_target;
  logic [7:0]       pcip;
  logic             pc_valid;
  logic             halted;
  logic             wrap;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output start, stall, opcode, branch_taken, branch_offset, jump, jump_target,
    input  pcip, pc_valid, halted, wrap, instr_count
  );
  modport slave (
    input  start, stall, opcode, branch_taken, branch_offset, jump, jump_target,
    output pcip, pc_valid, halted, wrap, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter generator with IDLE/RUN/HALT control, redirects, stall
// and a saturating retired-instruction counter.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [2:0] HALT_OPCODE = 3'b111,
  parameter int         CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t           r_state, w_state;
  logic [7:0]       r_pc, w_pc;
  logic             r_wrap, w_wrap;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             w_retire;
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_wrap   = 1'b0;
    w_retire = 1'b0;
    unique case (r_state)
      S_IDLE: w_state = bus.start ? S_RUN : S_IDLE;
      S_RUN: if (!bus.stall) begin
        w_retire = 1'b1;
        if (bus.opcode == HALT_OPCODE) w_state = S_HALT;
        else if (bus.jump) w_pc = bus.jump_target;
        else if (bus.branch_taken) w_pc = r_pc + 8'd1 + bus.branch_offset;
        else begin
          w_pc   = r_pc + 8'd1;
          w_wrap = r_pc == 8'hFF;
        end
      end
      S_HALT: if (bus.start) begin
        w_state = S_RUN;
        w_pc    = r_pc + 8'd1;
        w_wrap  = r_pc == 8'hFF;
      end
      default: w_state = S_IDLE;
    endcase
    w_cnt = (w_retire && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_wrap  <= w_wrap;
      r_cnt   <= w_cnt;
    end
  assign bus.pcip        = r_pc;
  assign bus.wrap        = r_wrap;
  assign bus.instr_count = r_cnt;
  assign bus.pc_valid    = r_state == S_RUN;
  assign bus.halted      = r_state == S_HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench; a second 4-bit-counter instance covers saturation.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  pc_sequencer_if #(.CNT_W(16)) b1 ();
  pc_sequencer_if #(.CNT_W(4))  b2 ();
  pc_sequencer #(.RESET_PC(8'h00), .HALT_OPCODE(3'b111), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  pc_sequencer #(.RESET_PC(8'h00), .HALT_OPCODE(3'b111), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_run(input string tag, input logic [7:0] pc, input logic [15:0] cnt, input logic wr);
    chk({tag, "_pc"}, 16'(b1.pcip), 16'(pc));
    chk({tag, "_cnt"}, b1.instr_count, cnt);
    chk({tag, "_wrap"}, 16'(b1.wrap), 16'(wr));
    chk({tag, "_valid"}, 16'(b1.pc_valid), 16'd1);
  endtask
  initial begin
    b1.start = 0; b1.stall = 0; b1.opcode = 0; b1.branch_taken = 0;
    b1.branch_offset = 0; b1.jump = 0; b1.jump_target = 0;
    b2.start = 0; b2.stall = 0; b2.opcode = 0; b2.branch_taken = 0;
    b2.branch_offset = 0; b2.jump = 0; b2.jump_target = 0;
    #12;
    chk("rst_pc", 16'(b1.pcip), 16'h00);
    chk("rst_valid", 16'(b1.pc_valid), 16'd0);
    chk("rst_halted", 16'(b1.halted), 16'd0);
    chk("rst_wrap", 16'(b1.wrap), 16'd0);
    chk("rst_cnt", b1.instr_count, 16'd0);
    rst_n = 1'b1;
    step();
    chk("idle_pc", 16'(b1.pcip), 16'h00);
    chk("idle_valid", 16'(b1.pc_valid), 16'd0);
    b1.start = 1;
    step();
    b1.start = 0;
    chk_run("enter", 8'h00, 16'd0, 1'b0);
    step(); chk_run("seq1", 8'h01, 16'd1, 1'b0);
    step(); chk_run("seq2", 8'h02, 16'd2, 1'b0);
    step(); chk_run("seq3", 8'h03, 16'd3, 1'b0);
    b1.jump = 1; b1.jump_target = 8'h10;
    step(); chk_run("jmp10", 8'h10, 16'd4, 1'b0);
    b1.jump = 0; b1.branch_taken = 1; b1.branch_offset = 8'hFE;
    step(); chk_run("br_back", 8'h0F, 16'd5, 1'b0);
    b1.jump = 1; b1.jump_target = 8'h40;
    step(); chk_run("jmp_prio", 8'h40, 16'd6, 1'b0);
    b1.branch_taken = 0; b1.jump_target = 8'h20;
    step(); chk_run("jmp20", 8'h20, 16'd7, 1'b0);
    b1.stall = 1; b1.jump_target = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step(); chk_run("stall", 8'h20, 16'd7, 1'b0);
    end
    b1.stall = 0;
    step(); chk_run("unstall", 8'h55, 16'd8, 1'b0);
    b1.jump_target = 8'hFF;
    step(); chk_run("jmpFF", 8'hFF, 16'd9, 1'b0);
    b1.jump = 0;
    step(); chk_run("wrap", 8'h00, 16'd10, 1'b1);
    step(); chk_run("post_wrap", 8'h01, 16'd11, 1'b0);
    b1.jump = 1; b1.jump_target = 8'hF0;
    step(); chk_run("jmpF0", 8'hF0, 16'd12, 1'b0);
    b1.jump = 0; b1.branch_taken = 1; b1.branch_offset = 8'h20;
    step(); chk_run("br_ovf", 8'h11, 16'd13, 1'b0);
    b1.branch_taken = 0; b1.jump = 1; b1.jump_target = 8'h07;
    step(); chk_run("jmp07", 8'h07, 16'd14, 1'b0);
    b1.jump = 0; b1.opcode = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_pc", 16'(b1.pcip), 16'h07);
      chk("halt_flag", 16'(b1.halted), 16'd1);
      chk("halt_valid", 16'(b1.pc_valid), 16'd0);
      chk("halt_cnt", b1.instr_count, 16'd15);
    end
    b1.opcode = 0; b1.start = 1;
    step();
    b1.start = 0;
    chk_run("resume", 8'h08, 16'd15, 1'b0);
    chk("resume_halted", 16'(b1.halted), 16'd0);
    b1.jump = 1; b1.jump_target = 8'h33;
    step(); chk_run("jmp33", 8'h33, 16'd16, 1'b0);
    b1.jump_target = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 16'(b1.pcip), 16'h00);
    chk("arst_cnt", b1.instr_count, 16'd0);
    chk("arst_valid", 16'(b1.pc_valid), 16'd0);
    chk("arst_halted", 16'(b1.halted), 16'd0);
    b1.jump = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_idle_pc", 16'(b1.pcip), 16'h00);
    chk("arst_idle_valid", 16'(b1.pc_valid), 16'd0);
    b2.start = 1;
    step();
    b2.start = 0;
    chk("sat_enter", 16'(b2.instr_count), 16'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_cnt", 16'(b2.instr_count), 16'(i > 15 ? 15 : i));
    end
    chk("sat_final", 16'(b2.instr_count), 16'h000F);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
